// File: rtl/ps2_pkg.sv
// ps2_pkg
//   Shared definitions for the PS/2 frame receiver:
//   - one-hot receiver state encoding
//   - parity mode selectors
//   - parity_ok() helper used by the frame checker
package ps2_pkg;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE   = 4'b0001;
  localparam state_t ST_DATA   = 4'b0010;
  localparam state_t ST_PARITY = 4'b0100;
  localparam state_t ST_STOP   = 4'b1000;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // data_xor is the XOR reduction of the received data bits. With no
  // parity bit in the frame every frame is considered parity-clean.
  function automatic logic parity_ok(input logic data_xor,
                                     input logic par_bit,
                                     input int   mode);
    logic total;
    total = data_xor ^ par_bit;
    case (mode)
      PARITY_ODD:  return total;
      PARITY_EVEN: return ~total;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//   Synchronous show-ahead FIFO for received PS/2 bytes.
//   Ports:
//     clk, reset       system clock, synchronous active-high reset
//     push, wr_data    write request and data (ignored when full unless
//                      a pop happens in the same cycle)
//     pop              advance the head (ignored when empty)
//     rd_data          current head, forced to 0 while empty
//     full, empty      status flags
//     count            number of entries held (0..FIFO_DEPTH)
module ps2_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  logic [DATA_BITS-1:0]            wr_data,
  input  logic                            pop,
  output logic [DATA_BITS-1:0]            rd_data,
  output logic                            full,
  output logic                            empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // When full, the write slot equals the head slot; a simultaneous pop
  // frees it in the same cycle, so the write is safe.
  assign do_push = push && (!full || do_pop);

  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Receives PS/2 device-to-host frames (start, DATA_BITS data LSB first,
//   optional parity, stop) sampled on pre-detected PS/2 clock edges.
//   Checks parity and stop bit, aborts a frame when the gap between edges
//   reaches TIMEOUT_CYCLES, and queues good frames in a show-ahead FIFO.
//
//   Ports:
//     clk, reset     system clock, synchronous active-high reset
//     rx_enable      allow new frames to start (a running frame completes)
//     clk_edge       one-cycle pulse at PS/2 clock falling edge
//     ps2_data       synchronised PS/2 data line
//     rd_en          pop the FIFO head
//     rx_data        FIFO head, valid while rx_valid
//     rx_valid       FIFO not empty
//     fifo_count     entries held
//     busy           frame in progress
//     parity_err     one-cycle pulse, parity mismatch
//     frame_err      one-cycle pulse, bad stop bit or inter-bit timeout
//     overflow       one-cycle pulse, good frame dropped (FIFO full)
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for a start bit (data low on an edge, rx_enable)
//   DATA   | shifting in DATA_BITS data bits, LSB first
//   PARITY | capturing the parity bit
//   STOP   | checking the stop bit and pushing/flagging the frame
module ps2_frame_receiver
  import ps2_pkg::*;
#(
  parameter int DATA_BITS      = 8,
  parameter int PARITY_MODE    = PARITY_ODD,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx_enable,
  input  logic                            clk_edge,
  input  logic                            ps2_data,
  input  logic                            rd_en,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            busy,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int BIT_CNT_W = $clog2(DATA_BITS + 1);
  localparam int TMR_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [TMR_W-1:0]       timer;
  logic [DATA_BITS-1:0]   sh;
  logic                   par_bit;

  logic                   start_det;
  logic                   timeout;
  logic                   stop_edge;
  logic                   stop_bad;
  logic                   par_bad;
  logic                   frame_good;
  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   parity_err_nxt;
  logic                   frame_err_nxt;
  logic                   overflow_nxt;

  assign start_det = (state == ST_IDLE) && clk_edge && !ps2_data && rx_enable;
  // An edge in the same cycle as terminal count keeps the frame alive.
  assign timeout   = (state != ST_IDLE) && !clk_edge && (timer == TMR_LAST);
  assign fifo_pop  = rd_en && !fifo_empty;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_det) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (timeout) state_nxt = ST_IDLE;
        else if (clk_edge && bit_cnt == LAST_BIT)
          state_nxt = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
      end
      ST_PARITY: begin
        if (timeout)       state_nxt = ST_IDLE;
        else if (clk_edge) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (timeout)       state_nxt = ST_IDLE;
        else if (clk_edge) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output / frame-check logic
  always_comb begin
    busy           = (state != ST_IDLE);
    stop_edge      = (state == ST_STOP) && clk_edge;
    stop_bad       = !ps2_data;
    par_bad        = (PARITY_MODE != PARITY_NONE) &&
                     !parity_ok(^sh, par_bit, PARITY_MODE);
    // Stop-bit errors take priority so each frame raises at most one pulse.
    frame_err_nxt  = timeout || (stop_edge && stop_bad);
    parity_err_nxt = stop_edge && !stop_bad && par_bad;
    frame_good     = stop_edge && !stop_bad && !par_bad;
    overflow_nxt   = frame_good && fifo_full && !fifo_pop;
    fifo_push      = frame_good && (!fifo_full || fifo_pop);
  end

  // Shift register, counters and registered error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt    <= '0;
      timer      <= '0;
      sh         <= '0;
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (state == ST_IDLE || clk_edge || timeout) timer <= '0;
      else                                         timer <= timer + 1'b1;

      if (start_det)                        bit_cnt <= '0;
      else if (state == ST_DATA && clk_edge) bit_cnt <= bit_cnt + 1'b1;

      if (state == ST_DATA && clk_edge)   sh      <= {ps2_data, sh[DATA_BITS-1:1]};
      if (state == ST_PARITY && clk_edge) par_bit <= ps2_data;

      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
      overflow   <= overflow_nxt;
    end
  end

  ps2_rx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (sh),
    .pop     (rd_en),
    .rd_data (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid = !fifo_empty;

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

  logic clk, reset, clk_edge, ps2_data;
  logic en_a, en_b, en_c, rd_en_a, rd_en_b, rd_en_c;

  // A: 8 data bits, odd parity, timeout 16, depth 4
  logic [7:0] a_rx_data;  logic a_rx_valid; logic [2:0] a_fifo_count;
  logic a_busy, a_parity_err, a_frame_err, a_overflow;
  // B: 7 data bits, no parity
  logic [6:0] b_rx_data;  logic b_rx_valid; logic [2:0] b_fifo_count;
  logic b_busy, b_parity_err, b_frame_err, b_overflow;
  // C: 8 data bits, even parity
  logic [7:0] c_rx_data;  logic c_rx_valid; logic [2:0] c_fifo_count;
  logic c_busy, c_parity_err, c_frame_err, c_overflow;

  int tests = 0;
  int fails = 0;

  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] q_c[$];

  int pe_a = 0, fe_a = 0, ov_a = 0, fe_b = 0, pe_c = 0, fe_c = 0;
  int exp_pe_a = 0, exp_fe_a = 0, exp_ov_a = 0, exp_fe_b = 0, exp_pe_c = 0, exp_fe_c = 0;

  ps2_frame_receiver #(.DATA_BITS(8), .PARITY_MODE(1), .TIMEOUT_CYCLES(16), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .rx_enable(en_a), .clk_edge(clk_edge), .ps2_data(ps2_data),
    .rd_en(rd_en_a), .rx_data(a_rx_data), .rx_valid(a_rx_valid), .fifo_count(a_fifo_count),
    .busy(a_busy), .parity_err(a_parity_err), .frame_err(a_frame_err), .overflow(a_overflow));

  ps2_frame_receiver #(.DATA_BITS(7), .PARITY_MODE(0), .TIMEOUT_CYCLES(16), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .rx_enable(en_b), .clk_edge(clk_edge), .ps2_data(ps2_data),
    .rd_en(rd_en_b), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .fifo_count(b_fifo_count),
    .busy(b_busy), .parity_err(b_parity_err), .frame_err(b_frame_err), .overflow(b_overflow));

  ps2_frame_receiver #(.DATA_BITS(8), .PARITY_MODE(2), .TIMEOUT_CYCLES(16), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset(reset), .rx_enable(en_c), .clk_edge(clk_edge), .ps2_data(ps2_data),
    .rd_en(rd_en_c), .rx_data(c_rx_data), .rx_valid(c_rx_valid), .fifo_count(c_fifo_count),
    .busy(c_busy), .parity_err(c_parity_err), .frame_err(c_frame_err), .overflow(c_overflow));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitors: a one-cycle pulse is counted exactly once.
  always @(negedge clk) begin
    if (a_parity_err === 1'b1) pe_a++;
    if (a_frame_err  === 1'b1) fe_a++;
    if (a_overflow   === 1'b1) ov_a++;
    if (b_frame_err  === 1'b1) fe_b++;
    if (c_parity_err === 1'b1) pe_c++;
    if (c_frame_err  === 1'b1) fe_c++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    repeat (3) tick();
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    clk_edge = 1'b1;
    tick();
    clk_edge = 1'b0;
    ps2_data = 1'b1;
  endtask

  function automatic logic par_of(input logic [8:0] d, input int n, input bit odd);
    logic x;
    x = 1'b0;
    for (int i = 0; i < n; i++) x ^= d[i];
    return odd ? ~x : x;
  endfunction

  // Returns right after the posedge that sampled the stop bit (+1ns).
  task automatic send_frame(input logic [8:0] d, input int n, input bit has_par,
                            input logic pb, input logic sb, input bit pop_a, input bit drop_en);
    send_bit(1'b0);
    if (drop_en) en_a = 1'b0;
    gap();
    for (int i = 0; i < n; i++) begin
      send_bit(d[i]);
      gap();
    end
    if (has_par) begin
      send_bit(pb);
      gap();
    end
    if (pop_a) rd_en_a = 1'b1;
    send_bit(sb);
    rd_en_a = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    int n;
    logic [8:0] e;
    n = q_a.size();
    for (int i = 0; i < n; i++) begin
      e = q_a.pop_front();
      tests++; if (a_rx_valid !== 1'b1) begin fails++; $display("FAIL %s_valid[%0d]: got %b want 1", tag, i, a_rx_valid); end
      tests++; if ({1'b0, a_rx_data} !== e) begin fails++; $display("FAIL %s_data[%0d]: got %h want %h", tag, i, a_rx_data, e); end
      rd_en_a = 1'b1;
      tick();
      rd_en_a = 1'b0;
    end
    tests++; if (a_rx_valid !== 1'b0) begin fails++; $display("FAIL %s_empty: rx_valid got %b want 0", tag, a_rx_valid); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL %s_count0: got %0d want 0", tag, a_fifo_count); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    tests++; if (a_rx_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", a_rx_valid); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", a_fifo_count); end
    tests++; if (a_rx_data !== 8'h00) begin fails++; $display("FAIL rst_data: got %h want 00", a_rx_data); end
    tests++; if ({a_parity_err, a_frame_err, a_overflow} !== 3'b000) begin fails++; $display("FAIL rst_err: got %b want 000", {a_parity_err, a_frame_err, a_overflow}); end
    tests++; if ({b_rx_valid, c_rx_valid, b_busy, c_busy} !== 4'b0000) begin fails++; $display("FAIL rst_bc: got %b want 0000", {b_rx_valid, c_rx_valid, b_busy, c_busy}); end
  endtask

  task automatic test_odd_good();
    q_a.push_back(9'h01C);
    send_frame(9'h01C, 8, 1, par_of(9'h01C, 8, 1), 1'b1, 0, 0);
    tests++; if (a_rx_valid !== 1'b1) begin fails++; $display("FAIL odd_valid: got %b want 1", a_rx_valid); end
    tests++; if (a_rx_data !== 8'h1C) begin fails++; $display("FAIL odd_data: got %h want 1c", a_rx_data); end
    tests++; if (a_fifo_count !== 3'd1) begin fails++; $display("FAIL odd_count: got %0d want 1", a_fifo_count); end
    tests++; if ({a_parity_err, a_frame_err, a_overflow} !== 3'b000) begin fails++; $display("FAIL odd_err: got %b want 000", {a_parity_err, a_frame_err, a_overflow}); end
    drain_a("odd");
  endtask

  task automatic test_errors();
    // wrong parity bit
    send_frame(9'h01C, 8, 1, 1'b1, 1'b1, 0, 0);
    exp_pe_a++;
    tests++; if ({a_parity_err, a_frame_err} !== 2'b10) begin fails++; $display("FAIL par_pulse: pe,fe got %b want 10", {a_parity_err, a_frame_err}); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL par_count: got %0d want 0", a_fifo_count); end
    tick();
    tests++; if (a_parity_err !== 1'b0) begin fails++; $display("FAIL par_single: got %b want 0", a_parity_err); end
    // bad stop bit, parity right
    send_frame(9'h01C, 8, 1, 1'b0, 1'b0, 0, 0);
    exp_fe_a++;
    tests++; if ({a_parity_err, a_frame_err} !== 2'b01) begin fails++; $display("FAIL stop_pulse: pe,fe got %b want 01", {a_parity_err, a_frame_err}); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL stop_count: got %0d want 0", a_fifo_count); end
    tick();
    // both stop and parity wrong
    send_frame(9'h01C, 8, 1, 1'b1, 1'b0, 0, 0);
    exp_fe_a++;
    tests++; if ({a_parity_err, a_frame_err} !== 2'b01) begin fails++; $display("FAIL both_pulse: pe,fe got %b want 01", {a_parity_err, a_frame_err}); end
    tick();
    tests++; if (a_frame_err !== 1'b0) begin fails++; $display("FAIL both_single: got %b want 0", a_frame_err); end
  endtask

  task automatic test_timeout();
    bit early;
    early = 0;
    send_bit(1'b0); gap();
    send_bit(1'b1); gap();
    send_bit(1'b0); gap();
    send_bit(1'b1);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i < 16 && (a_frame_err !== 1'b0 || a_busy !== 1'b1)) early = 1;
    end
    exp_fe_a++;
    tests++; if (early !== 1'b0) begin fails++; $display("FAIL to_early: early pulse/idle got %b want 0", early); end
    tests++; if (a_frame_err !== 1'b1) begin fails++; $display("FAIL to_pulse: got %b want 1", a_frame_err); end
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL to_busy: got %b want 0", a_busy); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL to_count: got %0d want 0", a_fifo_count); end
    tick();
    q_a.push_back(9'h0F0);
    send_frame(9'h0F0, 8, 1, par_of(9'h0F0, 8, 1), 1'b1, 0, 0);
    tests++; if ({a_parity_err, a_frame_err} !== 2'b00) begin fails++; $display("FAIL to_next_err: got %b want 00", {a_parity_err, a_frame_err}); end
    drain_a("to_next");
  endtask

  task automatic test_overflow();
    logic [8:0] d;
    for (int k = 1; k <= 5; k++) begin
      d = 9'(k);
      if (k <= 4) q_a.push_back(d);
      send_frame(d, 8, 1, par_of(d, 8, 1), 1'b1, 0, 0);
      if (k == 4) begin
        tests++; if (a_overflow !== 1'b0) begin fails++; $display("FAIL ovf_early: got %b want 0", a_overflow); end
      end
    end
    exp_ov_a++;
    tests++; if (a_overflow !== 1'b1) begin fails++; $display("FAIL ovf_pulse: got %b want 1", a_overflow); end
    tests++; if (a_fifo_count !== 3'd4) begin fails++; $display("FAIL ovf_count: got %0d want 4", a_fifo_count); end
    tick();
    tests++; if (a_overflow !== 1'b0) begin fails++; $display("FAIL ovf_single: got %b want 0", a_overflow); end
    drain_a("ovf");
  endtask

  task automatic test_full_pop();
    logic [8:0] d;
    logic [8:0] e;
    for (int k = 0; k < 4; k++) begin
      d = 9'h010 + 9'(k);
      q_a.push_back(d);
      send_frame(d, 8, 1, par_of(d, 8, 1), 1'b1, 0, 0);
    end
    tests++; if (a_fifo_count !== 3'd4) begin fails++; $display("FAIL fp_fill: got %0d want 4", a_fifo_count); end
    q_a.push_back(9'h0AA);
    e = q_a[0];
    send_frame(9'h0AA, 8, 1, par_of(9'h0AA, 8, 1), 1'b1, 1, 0);
    // the head popped on the stop-edge cycle
    void'(q_a.pop_front());
    tests++; if (e !== 9'h010) begin fails++; $display("FAIL fp_head: got %h want 010", e); end
    tests++; if (a_overflow !== 1'b0) begin fails++; $display("FAIL fp_ovf: got %b want 0", a_overflow); end
    tests++; if (a_fifo_count !== 3'd4) begin fails++; $display("FAIL fp_count: got %0d want 4", a_fifo_count); end
    drain_a("fp");
  endtask

  task automatic test_reset_mid();
    q_a.push_back(9'h033);
    send_frame(9'h033, 8, 1, par_of(9'h033, 8, 1), 1'b1, 0, 0);
    send_bit(1'b0); gap();
    for (int i = 0; i < 4; i++) begin send_bit(1'b1); gap(); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    q_a.delete();
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL rm_busy: got %b want 0", a_busy); end
    tests++; if (a_fifo_count !== 3'd0) begin fails++; $display("FAIL rm_count: got %0d want 0", a_fifo_count); end
    tests++; if (a_rx_valid !== 1'b0) begin fails++; $display("FAIL rm_valid: got %b want 0", a_rx_valid); end
    repeat (20) tick();
    tests++; if (fe_a !== exp_fe_a) begin fails++; $display("FAIL rm_nofe: frame_err count got %0d want %0d", fe_a, exp_fe_a); end
    q_a.push_back(9'h05A);
    send_frame(9'h05A, 8, 1, par_of(9'h05A, 8, 1), 1'b1, 0, 0);
    drain_a("rm_next");
  endtask

  task automatic test_enable();
    en_a = 1'b0;
    send_frame(9'h022, 8, 1, par_of(9'h022, 8, 1), 1'b1, 0, 0);
    tick();
    tests++; if ({a_busy, a_rx_valid} !== 2'b00) begin fails++; $display("FAIL en_off: busy,valid got %b want 00", {a_busy, a_rx_valid}); end
    en_a = 1'b1;
    q_a.push_back(9'h022);
    send_frame(9'h022, 8, 1, par_of(9'h022, 8, 1), 1'b1, 0, 1);
    tests++; if (a_fifo_count !== 3'd1) begin fails++; $display("FAIL en_drop_count: got %0d want 1", a_fifo_count); end
    drain_a("en_drop");
    en_a = 1'b0;
  endtask

  task automatic test_no_parity();
    logic [8:0] e;
    en_b = 1'b1;
    q_b.push_back(9'h041);
    send_frame(9'h041, 7, 0, 1'b0, 1'b1, 0, 0);
    e = q_b.pop_front();
    tests++; if (b_rx_valid !== 1'b1) begin fails++; $display("FAIL np_valid: got %b want 1", b_rx_valid); end
    tests++; if ({2'b00, b_rx_data} !== e) begin fails++; $display("FAIL np_data: got %h want %h", b_rx_data, e); end
    tests++; if (b_fifo_count !== 3'd1) begin fails++; $display("FAIL np_count: got %0d want 1", b_fifo_count); end
    rd_en_b = 1'b1; tick(); rd_en_b = 1'b0;
    tests++; if (b_rx_valid !== 1'b0) begin fails++; $display("FAIL np_empty: got %b want 0", b_rx_valid); end
    send_frame(9'h041, 7, 0, 1'b0, 1'b0, 0, 0);
    exp_fe_b++;
    tests++; if ({b_frame_err, b_fifo_count} !== 4'b1000) begin fails++; $display("FAIL np_stop: fe,count got %b want 1000", {b_frame_err, b_fifo_count}); end
    tick();
    en_b = 1'b0;
  endtask

  task automatic test_even();
    logic [8:0] e;
    en_c = 1'b1;
    q_c.push_back(9'h01C);
    send_frame(9'h01C, 8, 1, par_of(9'h01C, 8, 0), 1'b1, 0, 0);
    q_c.push_back(9'h0F0);
    send_frame(9'h0F0, 8, 1, par_of(9'h0F0, 8, 0), 1'b1, 0, 0);
    send_frame(9'h01C, 8, 1, par_of(9'h01C, 8, 1), 1'b1, 0, 0);
    exp_pe_c++;
    tests++; if (c_parity_err !== 1'b1) begin fails++; $display("FAIL ev_pe: got %b want 1", c_parity_err); end
    tests++; if (c_fifo_count !== 3'd2) begin fails++; $display("FAIL ev_count: got %0d want 2", c_fifo_count); end
    tick();
    while (q_c.size() > 0) begin
      e = q_c.pop_front();
      tests++; if ({1'b0, c_rx_data} !== e) begin fails++; $display("FAIL ev_data: got %h want %h", c_rx_data, e); end
      rd_en_c = 1'b1; tick(); rd_en_c = 1'b0;
    end
    tests++; if (c_rx_valid !== 1'b0) begin fails++; $display("FAIL ev_empty: got %b want 0", c_rx_valid); end
    en_c = 1'b0;
  endtask

  task automatic test_pulse_totals();
    tick();
    tests++; if (pe_a !== exp_pe_a) begin fails++; $display("FAIL tot_pe_a: got %0d want %0d", pe_a, exp_pe_a); end
    tests++; if (fe_a !== exp_fe_a) begin fails++; $display("FAIL tot_fe_a: got %0d want %0d", fe_a, exp_fe_a); end
    tests++; if (ov_a !== exp_ov_a) begin fails++; $display("FAIL tot_ov_a: got %0d want %0d", ov_a, exp_ov_a); end
    tests++; if (fe_b !== exp_fe_b) begin fails++; $display("FAIL tot_fe_b: got %0d want %0d", fe_b, exp_fe_b); end
    tests++; if (pe_c !== exp_pe_c) begin fails++; $display("FAIL tot_pe_c: got %0d want %0d", pe_c, exp_pe_c); end
    tests++; if (fe_c !== exp_fe_c) begin fails++; $display("FAIL tot_fe_c: got %0d want %0d", fe_c, exp_fe_c); end
  endtask

  initial begin
    reset = 1'b1; clk_edge = 1'b0; ps2_data = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rd_en_a = 1'b0; rd_en_b = 1'b0; rd_en_c = 1'b0;
    test_reset();
    en_a = 1'b1;
    test_odd_good();
    test_errors();
    test_timeout();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_enable();
    test_no_parity();
    test_even();
    test_pulse_totals();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
